// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and
// first-exception-wins capture. Define PIPE_STAGE_STATS_EN to add stall/drop counters.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned EXC_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_exc,
  input  logic [EXC_W-1:0]  in_exccode,
  input  logic [PC_W-1:0]   in_badvaddr,
  input  logic              local_exc,
  input  logic [EXC_W-1:0]  local_exccode,
  input  logic [PC_W-1:0]   local_badvaddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_exc,
  output logic [EXC_W-1:0]  out_exccode,
  output logic [PC_W-1:0]   out_badvaddr,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [15:0]       drop_cnt,
`endif
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic              exc;
    logic [EXC_W-1:0]  code;
    logic [PC_W-1:0]   badvaddr;
  } entry_t;

  // State encoding equals occupancy.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  entry_t merged;
  logic   accept, pop;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  // An exception carried from upstream is older than one raised here, so it wins.
  always_comb begin
    merged.data     = in_data;
    merged.pc       = in_pc;
    merged.exc      = 1'b0;
    merged.code     = '0;
    merged.badvaddr = in_pc;
    if (in_exc) begin
      merged.exc      = 1'b1;
      merged.code     = in_exccode;
      merged.badvaddr = in_badvaddr;
    end else if (local_exc) begin
      merged.exc      = 1'b1;
      merged.code     = local_exccode;
      merged.badvaddr = local_badvaddr;
    end
  end

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    in_ready_d = in_ready_q;
    if (flush) begin
      state_d    = StEmpty;
      main_d     = '0;
      skid_d     = '0;
      in_ready_d = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = merged;
          end
        end
        StOne: begin
          if (accept && !pop) begin
            state_d    = StFull;
            skid_d     = merged;
            in_ready_d = 1'b0;
          end else if (accept && pop) begin
            main_d = merged;
          end else if (pop) begin
            state_d = StEmpty;
            main_d  = '0;
          end
        end
        StFull: begin
          if (pop) begin
            state_d    = StOne;
            main_d     = skid_q;
            skid_d     = '0;
            in_ready_d = 1'b1;
          end
        end
        default: begin
          state_d    = StEmpty;
          main_d     = '0;
          skid_d     = '0;
          in_ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Bubbles present all-zero fields.
  always_comb begin
    out_data     = '0;
    out_pc       = '0;
    out_exc      = 1'b0;
    out_exccode  = '0;
    out_badvaddr = '0;
    if (out_valid) begin
      out_data     = main_q.data;
      out_pc       = main_q.pc;
      out_exc      = main_q.exc;
      out_exccode  = main_q.code;
      out_badvaddr = main_q.badvaddr;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  assign drop_sum  = {1'b0, drop_cnt_q} + {15'd0, occupancy};
  assign stall_cnt = stall_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush) begin
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed vector table plus randomised back-pressure scoreboard for pipe_skid_stage.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [63:0] in_data;
  logic [31:0] in_pc, in_badvaddr, local_badvaddr;
  logic        in_exc, local_exc;
  logic [4:0]  in_exccode, local_exccode;
  logic        out_valid, out_ready, out_exc;
  logic [63:0] out_data;
  logic [31:0] out_pc, out_badvaddr;
  logic [4:0]  out_exccode;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_pc          (in_pc),
    .in_exc         (in_exc),
    .in_exccode     (in_exccode),
    .in_badvaddr    (in_badvaddr),
    .local_exc      (local_exc),
    .local_exccode  (local_exccode),
    .local_badvaddr (local_badvaddr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_pc         (out_pc),
    .out_exc        (out_exc),
    .out_exccode    (out_exccode),
    .out_badvaddr   (out_badvaddr),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt      (stall_cnt),
    .drop_cnt       (drop_cnt),
`endif
    .occupancy      (occupancy)
  );

  typedef struct {
    logic rst, flush, iv;
    logic [63:0] d;
    logic [31:0] pc;
    logic ie;
    logic [4:0] ic;
    logic [31:0] ib;
    logic le;
    logic [4:0] lc;
    logic [31:0] lb;
    logic ordy;
    logic e_ir, e_ov;
    logic [63:0] e_d;
    logic [31:0] e_pc;
    logic e_exc;
    logic [4:0] e_code;
    logic [31:0] e_bad;
    logic [1:0] e_occ;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [31:0] pc;
    logic exc;
    logic [4:0] code;
    logic [31:0] bad;
  } ent_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_ir, input logic e_ov,
                          input ent_t e, input logic [1:0] e_occ);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(e_ir));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
    chk({tag, ".out_data"}, out_data, e.d);
    chk({tag, ".out_pc"}, 64'(out_pc), 64'(e.pc));
    chk({tag, ".out_exc"}, 64'(out_exc), 64'(e.exc));
    chk({tag, ".out_exccode"}, 64'(out_exccode), 64'(e.code));
    chk({tag, ".out_badvaddr"}, 64'(out_badvaddr), 64'(e.bad));
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(e_occ));
  endtask

  function automatic ent_t merge(input logic [63:0] d, input logic [31:0] pc,
                                 input logic ie, input logic [4:0] ic, input logic [31:0] ib,
                                 input logic le, input logic [4:0] lc, input logic [31:0] lb);
    ent_t m;
    m.d = d;
    m.pc = pc;
    if (ie) begin
      m.exc = 1'b1; m.code = ic; m.bad = ib;
    end else if (le) begin
      m.exc = 1'b1; m.code = lc; m.bad = lb;
    end else begin
      m.exc = 1'b0; m.code = 5'd0; m.bad = pc;
    end
    return m;
  endfunction

  vec_t vecs [24];
  ent_t q[$];
  ent_t ex, zero_ent;
  logic m_ir, acc, pp;
  int   stalls;
  logic [63:0] seq;

  initial begin
    zero_ent = '{d: '0, pc: '0, exc: 1'b0, code: '0, bad: '0};
    // rst flush iv data pc | ie ic ib | le lc lb | ordy || ir ov data pc exc code bad occ
    vecs[0]  = '{'0,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '0, '1,'0,'0,'0,'0,'0,'0,2'd0};
    vecs[1]  = '{'0,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '0, '1,'0,'0,'0,'0,'0,'0,2'd0};
    vecs[2]  = '{'1,'0,'1,64'h1234,32'hBFC0_0000, '0,'0,'0, '0,'0,'0, '1,
                 '1,'1,64'h1234,32'hBFC0_0000,'0,'0,32'hBFC0_0000,2'd1};
    vecs[3]  = '{'1,'0,'1,64'h1111,32'h4, '0,'0,'0, '0,'0,'0, '1,
                 '1,'1,64'h1111,32'h4,'0,'0,32'h4,2'd1};
    vecs[4]  = '{'1,'0,'1,64'h2222,32'h8, '0,'0,'0, '0,'0,'0, '1,
                 '1,'1,64'h2222,32'h8,'0,'0,32'h8,2'd1};
    vecs[5]  = '{'1,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '1, '1,'0,'0,'0,'0,'0,'0,2'd0};
    vecs[6]  = '{'1,'0,'1,64'hAAAA,32'h10, '0,'0,'0, '0,'0,'0, '0,
                 '1,'1,64'hAAAA,32'h10,'0,'0,32'h10,2'd1};
    vecs[7]  = '{'1,'0,'1,64'hBBBB,32'h14, '0,'0,'0, '0,'0,'0, '0,
                 '0,'1,64'hAAAA,32'h10,'0,'0,32'h10,2'd2};
    vecs[8]  = '{'1,'0,'1,64'hCCCC,32'h18, '0,'0,'0, '0,'0,'0, '0,
                 '0,'1,64'hAAAA,32'h10,'0,'0,32'h10,2'd2};
    vecs[9]  = '{'1,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '1,
                 '1,'1,64'hBBBB,32'h14,'0,'0,32'h14,2'd1};
    vecs[10] = '{'1,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '1, '1,'0,'0,'0,'0,'0,'0,2'd0};
    vecs[11] = '{'1,'0,'1,64'h55,32'h20, '1,5'h04,32'h21, '1,5'h0C,32'h8000_0003, '0,
                 '1,'1,64'h55,32'h20,'1,5'h04,32'h21,2'd1};
    vecs[12] = '{'1,'0,'1,64'h66,32'h24, '0,5'h04,'0, '1,5'h0C,32'h8000_0003, '1,
                 '1,'1,64'h66,32'h24,'1,5'h0C,32'h8000_0003,2'd1};
    vecs[13] = '{'1,'0,'1,64'h77,32'h28, '0,5'h1F,32'hDEAD, '0,5'h0C,32'hBEEF, '0,
                 '0,'1,64'h66,32'h24,'1,5'h0C,32'h8000_0003,2'd2};
    vecs[14] = '{'1,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '1,
                 '1,'1,64'h77,32'h28,'0,'0,32'h28,2'd1};
    vecs[15] = '{'1,'0,'1,64'h88,32'h30, '0,'0,'0, '0,'0,'0, '0,
                 '0,'1,64'h77,32'h28,'0,'0,32'h28,2'd2};
    vecs[16] = '{'1,'1,'1,64'h99,32'h34, '0,'0,'0, '0,'0,'0, '0, '1,'0,'0,'0,'0,'0,'0,2'd0};
    vecs[17] = '{'1,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '1, '1,'0,'0,'0,'0,'0,'0,2'd0};
    vecs[18] = '{'1,'0,'1,64'hA1,32'h40, '0,'0,'0, '0,'0,'0, '0,
                 '1,'1,64'hA1,32'h40,'0,'0,32'h40,2'd1};
    vecs[19] = '{'1,'0,'1,64'hA2,32'h44, '0,'0,'0, '0,'0,'0, '0,
                 '0,'1,64'hA1,32'h40,'0,'0,32'h40,2'd2};
    vecs[20] = '{'0,'0,'1,64'hA3,32'h48, '0,'0,'0, '0,'0,'0, '0, '1,'0,'0,'0,'0,'0,'0,2'd0};
    vecs[21] = '{'1,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '1, '1,'0,'0,'0,'0,'0,'0,2'd0};
    vecs[22] = '{'1,'0,'1,64'hB1,32'h50, '0,'0,'0, '0,'0,'0, '1,
                 '1,'1,64'hB1,32'h50,'0,'0,32'h50,2'd1};
    vecs[23] = '{'1,'0,'0,'0,'0, '0,'0,'0, '0,'0,'0, '1, '1,'0,'0,'0,'0,'0,'0,2'd0};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_pc = '0;
    in_exc = 1'b0; in_exccode = '0; in_badvaddr = '0;
    local_exc = 1'b0; local_exccode = '0; local_badvaddr = '0; out_ready = 1'b0;

    for (int i = 0; i < 24; i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
      in_data = vecs[i].d; in_pc = vecs[i].pc;
      in_exc = vecs[i].ie; in_exccode = vecs[i].ic; in_badvaddr = vecs[i].ib;
      local_exc = vecs[i].le; local_exccode = vecs[i].lc; local_badvaddr = vecs[i].lb;
      out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      ex = '{d: vecs[i].e_d, pc: vecs[i].e_pc, exc: vecs[i].e_exc, code: vecs[i].e_code,
             bad: vecs[i].e_bad};
      chk_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, ex, vecs[i].e_occ);
`ifdef PIPE_STAGE_STATS_EN
      if (i == 16) chk("vec16.drop_cnt", 64'(drop_cnt), 64'd2);
      if (i == 20) chk("vec20.stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    end

    // Random back-pressure against a queue model.
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_outs("rnd_reset", 1'b1, 1'b0, zero_ent, 2'd0);
    rst = 1'b1;
    q.delete();
    m_ir = 1'b1;
    stalls = 0;
    seq = 64'd1;
    for (int c = 0; c < 1000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = seq;
      in_pc = $urandom;
      in_exc = ($urandom_range(0, 7) == 0);
      in_exccode = 5'($urandom_range(0, 31));
      in_badvaddr = $urandom;
      local_exc = ($urandom_range(0, 7) == 0);
      local_exccode = 5'($urandom_range(0, 31));
      local_badvaddr = $urandom;
      acc = in_valid && m_ir;
      pp = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready) stalls++;
      ex = merge(in_data, in_pc, in_exc, in_exccode, in_badvaddr,
                 local_exc, local_exccode, local_badvaddr);
      @(posedge clk); #1;
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(ex);
        seq = seq + 64'd1;
      end
      m_ir = (q.size() < 2);
      chk_outs($sformatf("rnd%0d", c), m_ir, q.size() > 0,
               (q.size() > 0) ? q[0] : zero_ent, 2'(q.size()));
    end
`ifdef PIPE_STAGE_STATS_EN
    chk("rnd.stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generic payload register with valid/ready handshake, a 2-entry skid buffer, flush, and first-exception-wins capture of exception code and bad address.
- Sits between any two pipeline stages. It replaces ad-hoc `wr_en`/stall gating, so upstream can stall on a registered `in_ready` without a combinational ready path.

Parameters:
- DATA_W, 64, width of the opaque control+data payload
- PC_W, 32, width of the PC / bad-address fields
- EXC_W, 5, width of the exception code field

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- flush  in  1  discard all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  registered; stage can accept this cycle
- in_data  in  DATA_W  payload
- in_pc  in  PC_W  PC of the entry
- in_exc  in  1  entry already carries an exception
- in_exccode  in  EXC_W  code of the carried exception
- in_badvaddr  in  PC_W  bad address of the carried exception
- local_exc  in  1  exception detected in the current stage (overflow, AdEL/AdES, ...)
- local_exccode  in  EXC_W  code of the local exception
- local_badvaddr  in  PC_W  bad address of the local exception
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_pc  out  PC_W  head PC
- out_exc  out  1  head exception flag
- out_exccode  out  EXC_W  head exception code
- out_badvaddr  out  PC_W  head bad address
- occupancy  out  2  number of held entries, 0..2

Behaviour:
- Handshakes:
  - accept = in_valid && in_ready
  - pop = out_valid && out_ready
- Storage: main entry (head) and skid entry. Each entry holds {data, pc, exc, exccode, badvaddr}.
- Exception merge, applied on accept, priority in order:
  - in_exc=1: exc=1, code=in_exccode, badvaddr=in_badvaddr.
  - else local_exc=1: exc=1, code=local_exccode, badvaddr=local_badvaddr.
  - else: exc=0, code=0, badvaddr=in_pc.
- States, which equal occupancy:
  - EMPTY (0):
    - accept -> ONE; main <= merged input.
  - ONE (1):
    - accept && !pop -> FULL; skid <= input; in_ready <= 0.
    - accept && pop -> ONE; main <= input.
    - !accept && pop -> EMPTY.
    - otherwise hold.
  - FULL (2):
    - in_ready=0, so in_valid is ignored.
    - pop -> ONE; main <= skid; in_ready <= 1.
    - otherwise hold.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 entry/cycle when out_ready is held high.
- in_ready is a flop. It is 0 only in FULL.
- While out_valid && !out_ready, all out_* fields are held bit-stable.
- When out_valid=0, out_data/out_pc/out_exc/out_exccode/out_badvaddr are driven 0 (bubble = zeros).
- flush:
  - Next cycle: occupancy=0, out_valid=0, all entries zeroed, in_ready=1.
  - An accept in the flush cycle is discarded.
  - flush has priority over accept and pop, and is asserted by the hazard/CP0 unit.
- Reset (rst=0), equivalent to flush:
  - out_valid=0, all out_* = 0, occupancy=0, in_ready=1.
  - Reset mid-operation drops both entries.
- Entry order is strictly preserved. The skid entry never overtakes main.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt (32-bit): increments every cycle out_valid && !out_ready; saturates at 0xFFFF_FFFF.
  - drop_cnt (16-bit): adds the current occupancy on each flush cycle; saturates at 0xFFFF.
  - Both counters clear on reset only, not on flush.
- When undefined, the ports and counters are absent. Handshake behaviour is identical.

Test Plan:
- Reset then pass-through: hold rst=0 for 2 cycles, release; in_valid=1 with in_data=0x1234 and in_pc=0xBFC0_0000, out_ready=1 -> the next cycle shows out_valid=1, out_data=0x1234, out_exc=0, out_badvaddr=0xBFC0_0000, and a steady stream of 1 entry per cycle.
- Skid fill: out_ready=0; send A then B -> occupancy goes 1 then 2, in_ready=0 the cycle after B, and out_data stays A. Then out_ready=1 -> A pops, then B pops, and in_ready returns to 1 after the A pop.
- Exception priority: in_exc=1 with in_exccode=0x04 (AdEL) and local_exc=1 with local_exccode=0x0C (Ov) -> out_exccode=0x04. With in_exc=0, local_exc=1, local_badvaddr=0x8000_0003 -> out_exccode=0x0C, out_badvaddr=0x8000_0003.
- Flush while FULL with in_valid=1 in the same cycle -> the next cycle has occupancy=0, out_valid=0, in_ready=1, and the incoming entry never appears; with PIPE_STAGE_STATS_EN, drop_cnt=2.
- Reset mid-stream: assert rst=0 while occupancy=2 -> the next cycle has all outputs at 0 and in_ready=1, with no stale entry after release.
- Back-pressure stability: randomised out_ready for 1000 cycles against a scoreboard -> no loss, no duplication, order preserved, and outputs stable while stalled; with PIPE_STAGE_STATS_EN, stall_cnt equals the count of stalled cycles.
